// File: rtl/axis_pkt_deframer.sv
// Strips a length header from an AXI-Stream packet and passes the payload straight through.
// It reports length, checksum and error status once per packet. Oversize packets are dropped.
module axis_pkt_deframer #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              pkt_done,
    output logic [15:0]       pkt_len,
    output logic [DATA_W-1:0] pkt_sum,
    output logic              pkt_err,
    output logic [15:0]       pkt_count
);

    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t            state;
    logic [15:0]       remaining;
    logic [15:0]       len_q;
    logic [DATA_W-1:0] acc;
    logic              accept;
    logic [15:0]       hdr_len;
    logic [DATA_W-1:0] acc_next;

    // The payload path is purely combinational, so backpressure reaches upstream in the same cycle.
    assign s_ready  = (state == PAYLOAD) ? m_ready : 1'b1;
    assign accept   = s_valid && s_ready;
    assign m_valid  = (state == PAYLOAD) && s_valid;
    assign m_data   = s_data;
    assign m_last   = (state == PAYLOAD) && (remaining == 16'd1);
    assign hdr_len  = s_data[15:0];
    assign acc_next = acc + s_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HDR;
            remaining <= '0;
            len_q     <= '0;
            acc       <= '0;
            pkt_done  <= 1'b0;
            pkt_len   <= '0;
            pkt_sum   <= '0;
            pkt_err   <= 1'b0;
            pkt_count <= '0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                HDR: begin
                    if (accept) begin
                        remaining <= hdr_len;
                        len_q     <= hdr_len;
                        acc       <= '0;
                        if (hdr_len == 16'd0) begin
                            // An empty packet completes immediately with an error.
                            pkt_done  <= 1'b1;
                            pkt_len   <= '0;
                            pkt_sum   <= '0;
                            pkt_err   <= 1'b1;
                            pkt_count <= pkt_count + 16'd1;
                        end else if (hdr_len > MAX_LEN_W) begin
                            state <= DROP;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD, DROP: begin
                    if (accept) begin
                        acc       <= acc_next;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state     <= HDR;
                            pkt_done  <= 1'b1;
                            pkt_len   <= len_q;
                            pkt_sum   <= acc_next;
                            pkt_err   <= (state == DROP);
                            pkt_count <= pkt_count + 16'd1;
                        end
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule
